// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IWAIT    = 2'd1,
    IWAIT_RD = 2'd2,
    DWAIT    = 2'd3
  } hazard_state_t;

  // E-stage operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Per-operand E-stage forwarding select; M result beats W result.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: rs_e (E source index), rd_m/reg_write_m (M writer),
//        rd_w/reg_write_w (W writer), fwd_sel (FWD_* encoding).
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    // x0 is hardwired to zero, so a write to it must never be forwarded
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e))
      fwd_sel = FWD_MEM;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e))
      fwd_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard/stall controller: forwarding, load-use, cache-miss stalls, held redirect.
// Latency: controls combinational from inputs; state, RedirPCF and counters update on posedge clk.
// Backpressure: DMissM freezes every stage; IMissF holds F/D and bubbles E until the fetch completes.
// Ports: D/E/M/W register indices and write enables, ResultSrcE0, PCSrcE/PCTargetE,
//        IMissF/DMissM in; Stall*/Flush*, ForwardAE/BE, RedirSelF/RedirPCF, counters out.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        IMissF,
  input  logic        DMissM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        StallW,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        RedirSelF,
  output logic [31:0] RedirPCF,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  hazard_state_t state, state_nxt;
  logic          load_stall;
  logic          redir_load;

  forward_unit u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardAE)
  );

  forward_unit u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardBE)
  );

  assign load_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    redir_load = 1'b0;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    StallW     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    RedirSelF  = 1'b0;

    if (DMissM) begin
      // Freeze the whole pipe; a held redirect survives the D-miss untouched
      {StallF, StallD, StallE, StallM, StallW} = 5'b11111;
      state_nxt = (state == IWAIT_RD) ? IWAIT_RD : DWAIT;
    end else begin
      case (state)
        IWAIT_RD: begin
          if (IMissF) begin
            // Later branches in E are wrong-path behind the held redirect
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end else begin
            // Fetch done: drop the wrong-path instruction and steer PC to the held target
            RedirSelF = 1'b1;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            state_nxt = RUN;
          end
        end
        default: begin
          // RUN, IWAIT and DWAIT (miss cleared) all resolve with the same rules
          state_nxt = RUN;
          if (IMissF) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            if (PCSrcE) begin
              redir_load = 1'b1;
              state_nxt  = IWAIT_RD;
            end else begin
              state_nxt  = IWAIT;
            end
          end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (load_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RedirPCF   <= 32'd0;
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (redir_load) RedirPCF   <= PCTargetE;
      if (StallF)     StallCount <= StallCount + 32'd1;
      if (FlushE)     FlushCount <= FlushCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed miss/redirect/reset sequences,
// then random stimulus against a pending-redirect reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, IMissF, DMissM;
  logic [31:0] PCTargetE;
  logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, RedirSelF;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] RedirPCF, StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .IMissF(IMissF), .DMissM(DMissM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RedirSelF(RedirSelF), .RedirPCF(RedirPCF), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}
  function automatic logic [6:0] ctl_now();
    return {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; PCTargetE = 0;
    IMissF = 0; DMissM = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference: forwarding rule straight from the operand-select table
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] rdm, input logic rwm,
                                         input logic [4:0] rdw, input logic rww);
    if (rwm && rdm != 0 && rdm == rs) return 2'b10;
    if (rww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, ld, pcsrc, dmiss;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  vec_t vecs[12];

  // Reference model state: only "is a redirect being held" matters to the outputs
  bit          pend;
  logic [31:0] tgt_m, sc_m, fc_m;
  logic [6:0]  ectl;
  logic        ersel, lu;

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;

    //          rs1d rs2d rs1e rs2e rde rdm rdw rwm rww ld pc dm  fa     fb     ctl
    vecs[0]  = '{0,  0,   5,   0,   0,  5,  5,  1,  1,  0, 0, 0, 2'b10, 2'b00, 7'b0000000};
    vecs[1]  = '{0,  0,   5,   0,   0,  0,  5,  1,  1,  0, 0, 0, 2'b01, 2'b00, 7'b0000000};
    vecs[2]  = '{0,  0,   5,   0,   0,  0,  0,  1,  1,  0, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[3]  = '{0,  0,   3,   9,   0,  9,  9,  0,  1,  0, 0, 0, 2'b00, 2'b01, 7'b0000000};
    vecs[4]  = '{0,  0,   3,   9,   0,  9,  9,  1,  1,  0, 0, 0, 2'b00, 2'b10, 7'b0000000};
    vecs[5]  = '{0,  7,   0,   0,   7,  0,  0,  0,  0,  1, 0, 0, 2'b00, 2'b00, 7'b1100001};
    vecs[6]  = '{0,  0,   0,   0,   0,  0,  0,  0,  0,  1, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[7]  = '{7,  0,   0,   0,   7,  0,  0,  0,  0,  0, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[8]  = '{0,  0,   0,   0,   0,  0,  0,  0,  0,  0, 1, 0, 2'b00, 2'b00, 7'b0000011};
    vecs[9]  = '{7,  0,   0,   0,   7,  0,  0,  0,  0,  1, 1, 0, 2'b00, 2'b00, 7'b0000011};
    vecs[10] = '{7,  0,   0,   0,   7,  0,  0,  0,  0,  1, 1, 1, 2'b00, 2'b00, 7'b1111100};
    vecs[11] = '{0,  0,   5,   5,   0,  5,  5,  0,  0,  0, 0, 0, 2'b00, 2'b00, 7'b0000000};

    @(negedge clk);
    check("reset_stall_count", StallCount, 0);
    check("reset_flush_count", FlushCount, 0);
    check("reset_redir_pc", RedirPCF, 0);
    check("reset_redir_sel", {31'd0, RedirSelF}, 0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; ResultSrcE0 = vecs[i].ld;
      PCSrcE = vecs[i].pcsrc; DMissM = vecs[i].dmiss; IMissF = 1'b0;
      #1;
      check($sformatf("vec%0d_fwd_a", i), {30'd0, ForwardAE}, {30'd0, vecs[i].fa});
      check($sformatf("vec%0d_fwd_b", i), {30'd0, ForwardBE}, {30'd0, vecs[i].fb});
      check($sformatf("vec%0d_ctl", i), {25'd0, ctl_now()}, {25'd0, vecs[i].ctl});
      check($sformatf("vec%0d_redir_sel", i), {31'd0, RedirSelF}, 0);
    end

    // Load-use then branch: counter accounting
    do_reset();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    #1;
    check("lu_ctl", {25'd0, ctl_now()}, {25'd0, 7'b1100001});
    tick();
    clear_inputs();
    #1;
    check("lu_after_ctl", {25'd0, ctl_now()}, 0);
    check("lu_stall_count", StallCount, 1);
    check("lu_flush_count", FlushCount, 1);
    PCSrcE = 1;
    #1;
    check("br_ctl", {25'd0, ctl_now()}, {25'd0, 7'b0000011});
    tick();
    PCSrcE = 0;
    #1;
    check("br_flush_count", FlushCount, 2);
    check("br_stall_count", StallCount, 1);

    // Redirect resolved under an I-miss is held until the fetch returns
    IMissF = 1; PCSrcE = 1; PCTargetE = 32'h100;
    #1;
    check("rd_cap_ctl", {25'd0, ctl_now()}, {25'd0, 7'b1100001});
    check("rd_cap_sel", {31'd0, RedirSelF}, 0);
    tick();
    PCSrcE = 0; PCTargetE = 32'h200;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin PCSrcE = 1; PCTargetE = 32'h300; end
      else PCSrcE = 0;
      #1;
      check($sformatf("rd_wait%0d_pc", i), RedirPCF, 32'h100);
      check($sformatf("rd_wait%0d_ctl", i), {25'd0, ctl_now()}, {25'd0, 7'b1100001});
      check($sformatf("rd_wait%0d_sel", i), {31'd0, RedirSelF}, 0);
      tick();
    end
    PCSrcE = 0;
    IMissF = 0;
    #1;
    check("rd_fire_sel", {31'd0, RedirSelF}, 1);
    check("rd_fire_ctl", {25'd0, ctl_now()}, {25'd0, 7'b0000011});
    check("rd_fire_pc", RedirPCF, 32'h100);
    tick();
    #1;
    check("rd_done_sel", {31'd0, RedirSelF}, 0);
    check("rd_done_ctl", {25'd0, ctl_now()}, 0);

    // D-miss overrides a concurrent I-miss, which is then serviced
    DMissM = 1; IMissF = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("dm%0d_ctl", i), {25'd0, ctl_now()}, {25'd0, 7'b1111100});
      tick();
    end
    DMissM = 0;
    #1;
    check("dm_release_ctl", {25'd0, ctl_now()}, {25'd0, 7'b1100001});
    check("dm_release_sel", {31'd0, RedirSelF}, 0);
    tick();
    IMissF = 0;
    #1;
    check("dm_idle_ctl", {25'd0, ctl_now()}, 0);

    // Asynchronous reset in the middle of a held redirect
    IMissF = 1; PCSrcE = 1; PCTargetE = 32'h100;
    tick();
    PCSrcE = 0;
    #1;
    check("rst_pre_pc", RedirPCF, 32'h100);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_sel", {31'd0, RedirSelF}, 0);
    check("rst_pc", RedirPCF, 0);
    check("rst_stall_count", StallCount, 0);
    check("rst_flush_count", FlushCount, 0);
    check("rst_ctl", {25'd0, ctl_now()}, {25'd0, 7'b1100001});
    IMissF = 0;
    #1;
    reset_n = 1'b1;
    #1;
    check("rst_release_sel", {31'd0, RedirSelF}, 0);
    check("rst_release_ctl", {25'd0, ctl_now()}, 0);

    // Random stimulus against the reference model
    do_reset();
    pend = 0; tgt_m = 0; sc_m = 0; fc_m = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      ResultSrcE0 = ($urandom_range(0, 99) < 30);
      PCSrcE = ($urandom_range(0, 99) < 25);
      PCTargetE = $urandom;
      IMissF = ($urandom_range(0, 99) < (IMissF ? 70 : 20));
      DMissM = ($urandom_range(0, 99) < (DMissM ? 60 : 10));

      lu = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      ersel = 0;
      if (DMissM) ectl = 7'b1111100;
      else if (pend) begin
        if (IMissF) ectl = 7'b1100001;
        else begin ectl = 7'b0000011; ersel = 1; end
      end
      else if (IMissF) ectl = 7'b1100001;
      else if (PCSrcE) ectl = 7'b0000011;
      else if (lu) ectl = 7'b1100001;
      else ectl = 7'b0000000;

      #1;
      check("rnd_fwd_a", {30'd0, ForwardAE}, {30'd0, ref_fwd(Rs1E, RdM, RegWriteM, RdW, RegWriteW)});
      check("rnd_fwd_b", {30'd0, ForwardBE}, {30'd0, ref_fwd(Rs2E, RdM, RegWriteM, RdW, RegWriteW)});
      check("rnd_ctl", {25'd0, ctl_now()}, {25'd0, ectl});
      check("rnd_sel", {31'd0, RedirSelF}, {31'd0, ersel});
      check("rnd_pc", RedirPCF, tgt_m);
      check("rnd_stall_count", StallCount, sc_m);
      check("rnd_flush_count", FlushCount, fc_m);

      @(posedge clk);
      sc_m += {31'd0, ectl[6]};
      fc_m += {31'd0, ectl[0]};
      if (!DMissM) begin
        if (pend && !IMissF) pend = 0;
        else if (!pend && IMissF && PCSrcE) begin
          pend = 1;
          tgt_m = PCTargetE;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
